// File: rtl/screen_dump.sv
// screen_dump: walks the text VRAM row by row and replays it as a byte stream
// on a valid/ready source port. Each row ends with CR LF. An optional form feed
// is sent first. Control characters and DEL are replaced so the host terminal
// only ever sees printable text.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start; bus released to the terminal controller
// FF     | offering 8'h0C (form feed) ahead of row 0
// READ   | VRAM read strobe for {row, col}
// WAIT   | VRAM data arrives; substitute and latch it
// SEND   | offering the latched character
// CR     | offering 8'h0D at end of row
// LF     | offering 8'h0A; advance row or finish
// DONE   | one-cycle completion pulse, counters cleared
module screen_dump #(
  parameter logic [5:0] LAST_COL   = 6'd59,
  parameter logic [4:0] LAST_ROW   = 5'd16,
  parameter bit         SEND_FF    = 1'b1,
  parameter logic [7:0] SUBST_CHAR = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [10:0] o_vram_addr,
  output logic        o_vram_ce,
  output logic        o_vram_w,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  i_vram_dout,
  output logic [7:0]  o_char,
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FF,
    S_READ,
    S_WAIT,
    S_SEND,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [5:0] col, col_nx;
  logic [4:0] row, row_nx;
  logic [7:0] char_q, char_nx;
  logic       xfer;

  // o_valid is decoded from state, so a transfer depends on i_ready only
  // through the next-state logic, never through an output.
  assign xfer = o_valid & i_ready;

  // This block only ever reads VRAM.
  assign o_vram_w    = 1'b0;
  assign o_vram_din  = 8'h00;
  assign o_vram_addr = {row, col};

  // State, position counters and the latched character.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      char_q <= 8'h00;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      row    <= row_nx;
      char_q <= char_nx;
    end
  end

  // Next-state, counter advance and character substitution.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    char_nx  = char_q;
    case (state)
      S_IDLE: begin
        if (i_start) state_nx = SEND_FF ? S_FF : S_READ;
      end
      S_FF: begin
        if (xfer) state_nx = S_READ;
      end
      S_READ: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // 8'h80..8'hFF pass through untouched.
        if ((i_vram_dout < 8'h20) || (i_vram_dout == 8'h7F)) char_nx = SUBST_CHAR;
        else char_nx = i_vram_dout;
        state_nx = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (col == LAST_COL) begin
            state_nx = S_CR;
          end else begin
            col_nx   = col + 6'd1;
            state_nx = S_READ;
          end
        end
      end
      S_CR: begin
        if (xfer) state_nx = S_LF;
      end
      S_LF: begin
        if (xfer) begin
          if (row == LAST_ROW) begin
            state_nx = S_DONE;
          end else begin
            row_nx   = row + 5'd1;
            col_nx   = '0;
            state_nx = S_READ;
          end
        end
      end
      S_DONE: begin
        row_nx   = '0;
        col_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state only; they stay stable while a stall lasts.
  always_comb begin
    o_busy    = (state != S_IDLE);
    o_done    = (state == S_DONE);
    o_vram_ce = (state == S_READ);
    o_valid   = 1'b0;
    o_char    = 8'h00;
    case (state)
      S_FF: begin
        o_valid = 1'b1;
        o_char  = 8'h0C;
      end
      S_SEND: begin
        o_valid = 1'b1;
        o_char  = char_q;
      end
      S_CR: begin
        o_valid = 1'b1;
        o_char  = 8'h0D;
      end
      S_LF: begin
        o_valid = 1'b1;
        o_char  = 8'h0A;
      end
      default: begin
        o_valid = 1'b0;
        o_char  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_screen_dump.sv
// tb_screen_dump: drives two screen_dump instances (default geometry and a
// tiny 4x2 screen without form feed) against VRAM models, and compares the
// emitted byte streams with a stream built directly from the screen contents.
module tb_screen_dump;

  localparam int NONE = 1 << 30;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_ready;
  logic        o_busy, o_done, o_vram_ce, o_vram_w, o_valid;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_din, o_char, vram_dout;

  logic        s_start, s_ready;
  logic        s_busy, s_done, s_vram_ce, s_vram_w, s_valid;
  logic [10:0] s_vram_addr;
  logic [7:0]  s_vram_din, s_char, s_vram_dout;

  logic [7:0] vram   [0:2047];
  logic [7:0] s_vram [0:2047];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] s_got[$];
  logic [7:0] s_exp[$];

  int n_chk  = 0;
  int n_fail = 0;
  int nb, nd;

  always #5 i_clk = ~i_clk;

  screen_dump dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_vram_addr (o_vram_addr),
    .o_vram_ce   (o_vram_ce),
    .o_vram_w    (o_vram_w),
    .o_vram_din  (o_vram_din),
    .i_vram_dout (vram_dout),
    .o_char      (o_char),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  screen_dump #(
    .LAST_COL (6'd3),
    .LAST_ROW (5'd1),
    .SEND_FF  (1'b0)
  ) dut_small (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (s_start),
    .o_busy      (s_busy),
    .o_done      (s_done),
    .o_vram_addr (s_vram_addr),
    .o_vram_ce   (s_vram_ce),
    .o_vram_w    (s_vram_w),
    .o_vram_din  (s_vram_din),
    .i_vram_dout (s_vram_dout),
    .o_char      (s_char),
    .o_valid     (s_valid),
    .i_ready     (s_ready)
  );

  // Synchronous-read VRAM models: data one cycle after the strobe.
  always @(posedge i_clk) if (o_vram_ce) vram_dout <= vram[o_vram_addr];
  always @(posedge i_clk) if (s_vram_ce) s_vram_dout <= s_vram[s_vram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] subst(input logic [7:0] b);
    return ((b < 8'h20) || (b == 8'h7F)) ? 8'h20 : b;
  endfunction

  // Expected stream for the default 60x17 screen with leading form feed.
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'h0C);
    for (int r = 0; r <= 16; r++) begin
      for (int c = 0; c <= 59; c++) exp_q.push_back(subst(vram[r * 64 + c]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic fill_alpha();
    for (int a = 0; a < 2048; a++) vram[a] = 8'h41 + 8'((a % 64) % 26);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  // Starts a dump on the big instance and collects accepted bytes until it
  // returns to idle, with optional extra start pulse and mid-stream reset.
  task automatic run_big(input int duty, input int start_at, input int rst_at, input int max_cyc,
                         output int n_busy, output int n_done);
    logic       stalled;
    logic [7:0] stall_char;
    got_q.delete();
    n_busy     = 0;
    n_done     = 0;
    stalled    = 1'b0;
    stall_char = 8'h00;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge i_clk);
      i_start = (cyc == start_at);
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_char", o_char, stall_char);
      end
      if (cyc == rst_at + 2) begin
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ce", o_vram_ce, 0);
        check("rst_done", o_done, 0);
        i_rst = 1'b0;
        return;
      end
      i_rst = (cyc == rst_at) || (cyc == rst_at + 1);
      if (o_busy) n_busy++;
      if (o_done) n_done++;
      if (n_done > 0 && !o_busy) break;
      i_ready    = ($urandom_range(99) < duty);
      stalled    = o_valid && !i_ready && !i_rst;
      stall_char = o_char;
      if (o_valid && i_ready && !i_rst) got_q.push_back(o_char);
    end
    i_ready = 1'b1;
  endtask

  initial begin
    int sb, sd;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b1;
    s_start = 1'b0;
    s_ready = 1'b1;
    fill_alpha();
    for (int a = 0; a < 2048; a++) s_vram[a] = 8'h00;
    s_vram[0]  = 8'h61; s_vram[1]  = 8'h62; s_vram[2]  = 8'h63; s_vram[3]  = 8'h64;
    s_vram[64] = 8'h65; s_vram[65] = 8'h66; s_vram[66] = 8'h67; s_vram[67] = 8'h68;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("init_busy", o_busy, 0);
    check("init_done", o_done, 0);
    check("init_ce", o_vram_ce, 0);
    check("init_valid", o_valid, 0);
    check("init_char", o_char, 8'h00);
    check("init_addr", o_vram_addr, 0);
    i_rst = 1'b0;

    // Start coinciding with reset is dropped, not queued
    @(negedge i_clk);
    i_start = 1'b1;
    i_rst   = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst   = 1'b0;
    check("start_rst_busy", o_busy, 0);
    @(negedge i_clk);
    check("start_rst_noq", o_busy, 0);

    // Alphabet screen, sink always ready
    build_exp();
    run_big(100, NONE, NONE, 5000, nb, nd);
    compare_stream("t2");
    check("t2_busy_cycles", nb, 3096);
    check("t2_done_pulses", nd, 1);
    check("vram_w", o_vram_w, 0);
    check("vram_din", o_vram_din, 8'h00);

    // Same screen, sink ready about 30% of cycles
    run_big(30, NONE, NONE, 20000, nb, nd);
    compare_stream("t3");
    check("t3_done_pulses", nd, 1);

    // Random contents with explicit substitution cells
    for (int a = 0; a < 2048; a++) vram[a] = 8'($urandom);
    vram[2 * 64 + 5]   = 8'h07;
    vram[2 * 64 + 6]   = 8'h1F;
    vram[7 * 64 + 0]   = 8'h7F;
    vram[16 * 64 + 59] = 8'h80;
    build_exp();
    run_big(60, NONE, NONE, 12000, nb, nd);
    compare_stream("t4");
    check("t4_done_pulses", nd, 1);
    check("sub_07", got_q[1 + 2 * 62 + 5], 8'h20);
    check("sub_1f", got_q[1 + 2 * 62 + 6], 8'h20);
    check("sub_7f", got_q[1 + 7 * 62 + 0], 8'h20);
    check("sub_80", got_q[1 + 16 * 62 + 59], 8'h80);

    // Start during row 3 is ignored; reset during row 5; then a clean restart
    fill_alpha();
    build_exp();
    run_big(100, 560, 931, 2000, nb, nd);
    check("t5_prefix_len", (got_q.size() > 311), 1);
    check("t5_no_done", nd, 0);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("t5_prefix[%0d]", i), got_q[i], exp_q[i]);
    run_big(100, NONE, NONE, 5000, nb, nd);
    compare_stream("t5_restart");
    check("t5_busy_cycles", nb, 3096);
    check("t5_done_pulses", nd, 1);

    // Tiny 4x2 screen without form feed
    s_exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A, 8'h65, 8'h66, 8'h67, 8'h68, 8'h0D, 8'h0A};
    s_got.delete();
    sb = 0;
    sd = 0;
    @(negedge i_clk);
    s_start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge i_clk);
      s_start = 1'b0;
      if (s_busy) sb++;
      if (s_done) begin
        sd++;
        check("t6_len_at_done", s_got.size(), 12);
      end
      if (sd > 0 && !s_busy) break;
      if (s_valid && s_ready) s_got.push_back(s_char);
    end
    check("t6_len", s_got.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("t6[%0d]", i), s_got[i], s_exp[i]);
    check("t6_busy_cycles", sb, 29);
    check("t6_done_pulses", sd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
